// File: rtl/rv_pkg.sv
// Shared RV64I pipeline definitions: data widths, the canonical NOP and the
// fetch-stage controller state encoding.
package rv_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    // ADDI x0,x0,0
    localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC = 64'h0;

    typedef enum logic [1:0] {
        REQ     = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2,
        HOLD    = 2'd3
    } fetch_state_e;

endpackage : rv_pkg

// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: owns the fetch PC, runs a single-outstanding
// request/grant/response handshake to instruction memory and presents
// {pc_F, inst_F} plus the `waiting` hold to the IF/ID register.
//
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   stall              hazard stall, IF/ID holds
//   jb, jb_target      execute-stage redirect (target bits [1:0] ignored)
//   imem_req/addr      request to instruction memory
//   imem_gnt           request accepted this cycle
//   imem_rvalid/rdata  instruction response
//   pc_F, inst_F       presented PC / instruction (NOP_INST when none)
//   waiting            1 = nothing valid presented this cycle
module fetch_ctrl #(
    parameter int unsigned                XLEN     = rv_pkg::XLEN,
    parameter logic [XLEN-1:0]            RESET_PC = rv_pkg::RESET_PC,
    parameter logic [rv_pkg::ILEN-1:0]    NOP_INST = rv_pkg::NOP_INST
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic                     jb,
    input  logic [XLEN-1:0]          jb_target,
    output logic                     imem_req,
    output logic [XLEN-1:0]          imem_addr,
    input  logic                     imem_gnt,
    input  logic                     imem_rvalid,
    input  logic [rv_pkg::ILEN-1:0]  imem_rdata,
    output logic [XLEN-1:0]          pc_F,
    output logic [rv_pkg::ILEN-1:0]  inst_F,
    output logic                     waiting
);

    import rv_pkg::*;

    fetch_state_e      state;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   req_pc;
    logic [XLEN-1:0]   hold_pc;
    logic [ILEN-1:0]   hold_inst;
    logic [XLEN-1:0]   jb_tgt;

    // Redirect targets are always word aligned.
    assign jb_tgt = {jb_target[XLEN-1:2], 2'b00};

    // State and fetch datapath; redirect takes priority over stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= REQ;
            pc        <= RESET_PC;
            req_pc    <= '0;
            hold_pc   <= '0;
            hold_inst <= '0;
        end else begin
            case (state)
                REQ: begin
                    if (imem_gnt) begin
                        if (jb) begin
                            // Granted request is already stale.
                            pc    <= jb_tgt;
                            state <= DISCARD;
                        end else begin
                            req_pc <= pc;
                            state  <= WAIT;
                        end
                    end else if (jb) begin
                        pc <= jb_tgt;
                    end
                end
                WAIT: begin
                    if (!imem_rvalid) begin
                        if (jb) begin
                            pc    <= jb_tgt;
                            state <= DISCARD;
                        end
                    end else if (jb) begin
                        pc    <= jb_tgt;
                        state <= REQ;
                    end else if (!stall) begin
                        pc    <= req_pc + XLEN'(4);
                        state <= REQ;
                    end else begin
                        hold_inst <= imem_rdata;
                        hold_pc   <= req_pc;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (jb) begin
                        pc    <= jb_tgt;
                        state <= REQ;
                    end else if (!stall) begin
                        pc    <= hold_pc + XLEN'(4);
                        state <= REQ;
                    end
                end
                DISCARD: begin
                    if (jb) begin
                        pc <= jb_tgt;
                    end
                    if (imem_rvalid) begin
                        state <= REQ;
                    end
                end
                default: state <= REQ;
            endcase
        end
    end

    // Presentation and request drive; the WAIT response is bypassed to IF/ID
    // in the cycle it arrives, so these are decoded from state and inputs.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc;
        pc_F      = pc;
        inst_F    = NOP_INST;
        waiting   = 1'b1;
        if (!rst) begin
            pc_F = '0;
        end else begin
            case (state)
                REQ: imem_req = 1'b1;
                WAIT: begin
                    if (imem_rvalid && !jb) begin
                        inst_F  = imem_rdata;
                        pc_F    = req_pc;
                        waiting = 1'b0;
                    end
                end
                HOLD: begin
                    inst_F  = hold_inst;
                    pc_F    = hold_pc;
                    waiting = 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule : fetch_ctrl

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: inputs change on the falling edge and
// outputs are sampled 1 time unit later, well away from the rising edge.
module tb_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        jb;
    logic [63:0] jb_target;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [63:0] pc_F;
    logic [31:0] inst_F;
    logic        waiting;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .jb         (jb),
        .jb_target  (jb_target),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .pc_F       (pc_F),
        .inst_F     (inst_F),
        .waiting    (waiting)
    );

    // Drive one cycle of inputs on the falling edge, then settle.
    task automatic drive(input logic s, input logic j, input logic [63:0] t,
                         input logic g, input logic rv, input logic [31:0] rd);
        @(negedge clk);
        stall       = s;
        jb          = j;
        jb_target   = t;
        imem_gnt    = g;
        imem_rvalid = rv;
        imem_rdata  = rd;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(0, 0, 64'h0, 0, 0, 32'h0);
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%0b exp=0", imem_req); end
        total++; if (pc_F !== 64'h0) begin bad++; $display("FAIL reset_pcF got=%h exp=0", pc_F); end
        total++; if (inst_F !== NOP) begin bad++; $display("FAIL reset_inst got=%h exp=%h", inst_F, NOP); end
        total++; if (waiting !== 1'b1) begin bad++; $display("FAIL reset_wait got=%0b exp=1", waiting); end
    endtask

    task automatic test_first_fetch();
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 64'h0, 1, 0, 32'h0);
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL first_req got=%0b exp=1", imem_req); end
        total++; if (imem_addr !== 64'h0) begin bad++; $display("FAIL first_addr got=%h exp=0", imem_addr); end
        total++; if (waiting !== 1'b1) begin bad++; $display("FAIL first_wait_req got=%0b exp=1", waiting); end
        drive(0, 0, 64'h0, 0, 0, 32'h0);
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL first_req_wait got=%0b exp=0", imem_req); end
        total++; if (waiting !== 1'b1) begin bad++; $display("FAIL first_wait_gap got=%0b exp=1", waiting); end
        drive(0, 0, 64'h0, 0, 1, 32'h0050_0093);
        total++; if (inst_F !== 32'h0050_0093) begin bad++; $display("FAIL first_inst got=%h exp=00500093", inst_F); end
        total++; if (pc_F !== 64'h0) begin bad++; $display("FAIL first_pcF got=%h exp=0", pc_F); end
        total++; if (waiting !== 1'b0) begin bad++; $display("FAIL first_wait_present got=%0b exp=0", waiting); end
        drive(0, 0, 64'h0, 0, 0, 32'h0);
        total++; if (waiting !== 1'b1) begin bad++; $display("FAIL first_wait_after got=%0b exp=1", waiting); end
        total++; if (imem_addr !== 64'h4) begin bad++; $display("FAIL first_next_addr got=%h exp=4", imem_addr); end
        total++; if (inst_F !== NOP) begin bad++; $display("FAIL first_nop_after got=%h exp=%h", inst_F, NOP); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_pc;
        logic [31:0] word;
        for (int i = 0; i < 3; i++) begin
            exp_pc = 64'h4 + 64'(4 * i);
            word   = 32'h0000_0093 + 32'(i << 20);
            drive(0, 0, 64'h0, 1, 0, 32'h0);
            total++; if (imem_addr !== exp_pc) begin bad++; $display("FAIL b2b_addr[%0d] got=%h exp=%h", i, imem_addr, exp_pc); end
            total++; if (waiting !== 1'b1) begin bad++; $display("FAIL b2b_wait_req[%0d] got=%0b exp=1", i, waiting); end
            drive(0, 0, 64'h0, 0, 1, word);
            total++; if (pc_F !== exp_pc) begin bad++; $display("FAIL b2b_pcF[%0d] got=%h exp=%h", i, pc_F, exp_pc); end
            total++; if (inst_F !== word) begin bad++; $display("FAIL b2b_inst[%0d] got=%h exp=%h", i, inst_F, word); end
            total++; if (waiting !== 1'b0) begin bad++; $display("FAIL b2b_wait[%0d] got=%0b exp=0", i, waiting); end
        end
    endtask

    task automatic test_jb_in_wait();
        drive(0, 0, 64'h0, 1, 0, 32'h0);
        total++; if (imem_addr !== 64'h10) begin bad++; $display("FAIL jbw_addr got=%h exp=10", imem_addr); end
        drive(0, 1, 64'h100, 0, 0, 32'h0);
        total++; if (waiting !== 1'b1) begin bad++; $display("FAIL jbw_wait got=%0b exp=1", waiting); end
        drive(0, 0, 64'h0, 0, 1, 32'hDEAD_BEEF);
        total++; if (inst_F !== NOP) begin bad++; $display("FAIL jbw_stale_inst got=%h exp=%h", inst_F, NOP); end
        total++; if (waiting !== 1'b1) begin bad++; $display("FAIL jbw_stale_wait got=%0b exp=1", waiting); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL jbw_discard_req got=%0b exp=0", imem_req); end
        drive(0, 0, 64'h0, 0, 0, 32'h0);
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL jbw_req got=%0b exp=1", imem_req); end
        total++; if (imem_addr !== 64'h100) begin bad++; $display("FAIL jbw_new_addr got=%h exp=100", imem_addr); end
    endtask

    task automatic test_gnt_jb();
        drive(0, 1, 64'h203, 1, 0, 32'h0);
        total++; if (imem_addr !== 64'h100) begin bad++; $display("FAIL gj_addr got=%h exp=100", imem_addr); end
        drive(0, 0, 64'h0, 0, 0, 32'h0);
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL gj_req got=%0b exp=0", imem_req); end
        drive(0, 0, 64'h0, 0, 1, 32'h1111_1111);
        total++; if (waiting !== 1'b1) begin bad++; $display("FAIL gj_wait got=%0b exp=1", waiting); end
        total++; if (inst_F !== NOP) begin bad++; $display("FAIL gj_inst got=%h exp=%h", inst_F, NOP); end
        drive(0, 0, 64'h0, 0, 0, 32'h0);
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL gj_req2 got=%0b exp=1", imem_req); end
        total++; if (imem_addr !== 64'h200) begin bad++; $display("FAIL gj_new_addr got=%h exp=200", imem_addr); end
    endtask

    task automatic test_stall_hold();
        // Redirect while waiting for grant: address follows next cycle.
        drive(0, 1, 64'h8, 0, 0, 32'h0);
        total++; if (imem_addr !== 64'h200) begin bad++; $display("FAIL st_addr_old got=%h exp=200", imem_addr); end
        drive(0, 0, 64'h0, 1, 0, 32'h0);
        total++; if (imem_addr !== 64'h8) begin bad++; $display("FAIL st_addr got=%h exp=8", imem_addr); end
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 64'h0, 0, (i == 0), (i == 0) ? 32'h00A0_0113 : 32'h0);
            total++; if (inst_F !== 32'h00A0_0113) begin bad++; $display("FAIL st_inst[%0d] got=%h exp=00a00113", i, inst_F); end
            total++; if (pc_F !== 64'h8) begin bad++; $display("FAIL st_pcF[%0d] got=%h exp=8", i, pc_F); end
            total++; if (waiting !== 1'b0) begin bad++; $display("FAIL st_wait[%0d] got=%0b exp=0", i, waiting); end
            total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL st_req[%0d] got=%0b exp=0", i, imem_req); end
        end
        drive(0, 0, 64'h0, 0, 0, 32'h0);
        total++; if (inst_F !== 32'h00A0_0113) begin bad++; $display("FAIL st_release_inst got=%h exp=00a00113", inst_F); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL st_release_req got=%0b exp=0", imem_req); end
        drive(0, 0, 64'h0, 0, 0, 32'h0);
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL st_next_req got=%0b exp=1", imem_req); end
        total++; if (imem_addr !== 64'hC) begin bad++; $display("FAIL st_next_addr got=%h exp=c", imem_addr); end
    endtask

    task automatic test_reset_in_wait();
        drive(0, 0, 64'h0, 1, 0, 32'h0);
        drive(0, 0, 64'h0, 0, 0, 32'h0);
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rw_in_wait got=%0b exp=0", imem_req); end
        rst = 1'b0;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rw_req got=%0b exp=0", imem_req); end
        total++; if (inst_F !== NOP) begin bad++; $display("FAIL rw_inst got=%h exp=%h", inst_F, NOP); end
        total++; if (waiting !== 1'b1) begin bad++; $display("FAIL rw_wait got=%0b exp=1", waiting); end
        total++; if (pc_F !== 64'h0) begin bad++; $display("FAIL rw_pcF got=%h exp=0", pc_F); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rw_req_after got=%0b exp=1", imem_req); end
        total++; if (imem_addr !== 64'h0) begin bad++; $display("FAIL rw_addr_after got=%h exp=0", imem_addr); end
    endtask

    initial begin
        rst         = 1'b0;
        stall       = 1'b0;
        jb          = 1'b0;
        jb_target   = 64'h0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        test_reset();
        test_first_fetch();
        test_back_to_back();
        test_jb_in_wait();
        test_gnt_jb();
        test_stall_hold();
        test_reset_in_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fetch_ctrl
